// File: rtl/otter_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side register/control info in, stall, flush and
// forwarding controls out. The controller connects as slave, the pipeline datapath as master.
interface otter_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       de_rs1_addr;
  logic [4:0]       de_rs2_addr;
  logic             de_rs1_used;
  logic             de_rs2_used;
  logic [4:0]       ex_rs1_addr;
  logic [4:0]       ex_rs2_addr;
  logic [4:0]       ex_rd_addr;
  logic             ex_regWrite;
  logic             ex_memRead2;
  logic             ex_redirect;
  logic [4:0]       mem_rd_addr;
  logic             mem_regWrite;
  logic [4:0]       wb_rd_addr;
  logic             wb_regWrite;

  logic             pc_write;
  logic             if_de_write;
  logic             if_de_flush;
  logic             de_ex_flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             de_byp1;
  logic             de_byp2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_regWrite, ex_memRead2, ex_redirect,
           mem_rd_addr, mem_regWrite, wb_rd_addr, wb_regWrite,
    input  pc_write, if_de_write, if_de_flush, de_ex_flush,
           fwd_a_sel, fwd_b_sel, de_byp1, de_byp2, stall_cnt, flush_cnt
  );

  modport slave (
    input  de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_regWrite, ex_memRead2, ex_redirect,
           mem_rd_addr, mem_regWrite, wb_rd_addr, wb_regWrite,
    output pc_write, if_de_write, if_de_flush, de_ex_flush,
           fwd_a_sel, fwd_b_sel, de_byp1, de_byp2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/otter_hazard_ctrl.sv
// OTTER 5-stage hazard controller: per-stage valid tracking, load-use stall, EX redirect
// squash, EX operand forwarding, DE write-back bypass and stall/flush counters.
module otter_hazard_ctrl #(
  parameter int CNT_W         = 32,
  parameter int FLUSH_BUBBLES = 2
) (
  input logic                CLK,
  input logic                RESET,
  otter_hazard_ctrl_if.slave hz
);
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] LU_STALL = 1'b1;

  logic [0:0]       state;
  logic             v_de, v_ex, v_mem, v_wb;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             lu, redirect, stall;
  logic             pc_write, if_de_write, if_de_flush, de_ex_flush;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             de_byp1, de_byp2;
  logic             mem_wr, wb_wr;

  // A stage's write only counts when it holds a real instruction and targets a non-x0 register.
  assign mem_wr = v_mem & hz.mem_regWrite & (hz.mem_rd_addr != 5'd0);
  assign wb_wr  = v_wb  & hz.wb_regWrite  & (hz.wb_rd_addr  != 5'd0);

  assign redirect = v_ex & hz.ex_redirect;
  assign lu = v_ex & hz.ex_memRead2 & hz.ex_regWrite & (hz.ex_rd_addr != 5'd0) & v_de &
              ((hz.de_rs1_used & (hz.de_rs1_addr == hz.ex_rd_addr)) |
               (hz.de_rs2_used & (hz.de_rs2_addr == hz.ex_rd_addr)));
  // A redirect makes the DE consumer wrong-path, so it never stalls.
  assign stall = (state == RUN) & lu & ~redirect;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       m_en, input logic [4:0] m_rd,
                                         input logic       w_en, input logic [4:0] w_rd);
    if (m_en && (m_rd == rs))      return 2'd1;
    else if (w_en && (w_rd == rs)) return 2'd2;
    else                           return 2'd0;
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    pc_write    = 1'b1;
    if_de_write = 1'b1;
    if_de_flush = 1'b0;
    de_ex_flush = 1'b0;
    fwd_a_sel   = fwd_sel(hz.ex_rs1_addr, mem_wr, hz.mem_rd_addr, wb_wr, hz.wb_rd_addr);
    fwd_b_sel   = fwd_sel(hz.ex_rs2_addr, mem_wr, hz.mem_rd_addr, wb_wr, hz.wb_rd_addr);
    de_byp1     = wb_wr & (hz.wb_rd_addr == hz.de_rs1_addr);
    de_byp2     = wb_wr & (hz.wb_rd_addr == hz.de_rs2_addr);
    if (RESET) begin
      pc_write    = 1'b0;
      if_de_write = 1'b0;
      if_de_flush = 1'b1;
      de_ex_flush = 1'b1;
      fwd_a_sel   = 2'd0;
      fwd_b_sel   = 2'd0;
      de_byp1     = 1'b0;
      de_byp2     = 1'b0;
    end else if (redirect) begin
      if_de_flush = (FLUSH_BUBBLES >= 1);
      de_ex_flush = (FLUSH_BUBBLES >= 2);
    end else if (stall) begin
      pc_write    = 1'b0;
      if_de_write = 1'b0;
      de_ex_flush = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= RUN;
      v_de      <= 1'b0;
      v_ex      <= 1'b0;
      v_mem     <= 1'b0;
      v_wb      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= stall ? LU_STALL : RUN;
      if (if_de_write) v_de <= ~if_de_flush;
      v_ex  <= v_de & ~de_ex_flush;
      v_mem <= v_ex;
      v_wb  <= v_mem;
      if (stall)    stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.if_de_write = if_de_write;
  assign hz.if_de_flush = if_de_flush;
  assign hz.de_ex_flush = de_ex_flush;
  assign hz.fwd_a_sel   = fwd_a_sel;
  assign hz.fwd_b_sel   = fwd_b_sel;
  assign hz.de_byp1     = de_byp1;
  assign hz.de_byp2     = de_byp2;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;
endmodule
